// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
package regfile_wb_arbiter_pkg;

    // Architectural data width of the integer register file.
    localparam int ARCH_WIDTH     = 64;

    // Register address width and number of architectural registers.
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    // Scoreboard mask that keeps x0 permanently non-busy.
    localparam logic [NUM_REGS-1:0] BUSY_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: the most recently granted requester gets the
// lowest priority on the next cycle. The pointer only moves when the owner
// signals that the granted request was actually consumed.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    input  logic         advance
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic          found;

    // Search from ptr+1 upward (wrapping) and grant the first active request.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        found     = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!found && req[(int'(ptr) + off) % N]) begin
                grant[(int'(ptr) + off) % N] = 1'b1;
                grant_idx = PW'((int'(ptr) + off) % N);
                found     = 1'b1;
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

    // Remember the last consumed grant; reset makes requester 0 highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PW'(N - 1);
        end else if (advance && found) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port among several writeback sources,
// registers the winning write, and keeps a scoreboard of destination registers
// with writes still in flight so decode can stall RAW/WAW hazards.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int DW    = ARCH_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC-1:0]              wb_valid,
    output logic [N_SRC-1:0]              wb_ready,
    input  logic [REG_ADDR_WIDTH*N_SRC-1:0] wb_rd,
    input  logic [DW*N_SRC-1:0]           wb_data,
    output logic                          rf_we,
    output logic [REG_ADDR_WIDTH-1:0]     rf_rd,
    output logic [DW-1:0]                 rf_data,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]     issue_rd,
    output logic                          issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     rs1,
    input  logic [REG_ADDR_WIDTH-1:0]     rs2,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          wb_err
);

    localparam int AW = REG_ADDR_WIDTH;

    logic [N_SRC-1:0]    transfer;
    logic                xfer_any;
    reg_addr_t           xfer_rd;
    logic [DW-1:0]       xfer_data;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    rr_arbiter #(
        .N(N_SRC)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (wb_valid),
        .grant  (wb_ready),
        .advance(xfer_any)
    );

    assign transfer = wb_valid & wb_ready;
    assign xfer_any = |transfer;

    // Select the rd/data of the single accepted source.
    always_comb begin
        xfer_rd   = '0;
        xfer_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (transfer[i]) begin
                xfer_rd   = wb_rd[AW*i +: AW];
                xfer_data = wb_data[DW*i +: DW];
            end
        end
    end

    // Build the scoreboard set/clear vectors; x0 is never tracked.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_ready && issue_rd != '0) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (xfer_any && xfer_rd != '0) begin
            clr_mask[xfer_rd] = 1'b1;
        end
    end

    assign issue_ready = !rst && (!busy[issue_rd] || issue_rd == '0);
    assign rs1_busy    = busy[rs1];
    assign rs2_busy    = busy[rs2];

    // Registered write stage: one cycle after acceptance the write reaches reg_file.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= xfer_any && (xfer_rd != '0);
            if (xfer_any) begin
                rf_rd   <= xfer_rd;
                rf_data <= xfer_data;
            end
        end
    end

    // Scoreboard update: a newly issued producer wins over a same-edge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & BUSY_MASK;
        end
    end

    // Sticky flag for writebacks that nobody was waiting on.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (xfer_any && xfer_rd != '0 && !busy[xfer_rd]) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with three writeback sources.
module tb_regfile_wb_arbiter;

    localparam int N_SRC = 3;
    localparam int DW    = 64;

    logic              clk;
    logic              rst;
    logic [N_SRC-1:0]  wb_valid;
    logic [N_SRC-1:0]  wb_ready;
    logic [5*N_SRC-1:0] wb_rd;
    logic [DW*N_SRC-1:0] wb_data;
    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [DW-1:0]     rf_data;
    logic              issue_valid;
    logic [4:0]        issue_rd;
    logic              issue_ready;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wb_err;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(
        .N_SRC(N_SRC),
        .DW   (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .wb_err     (wb_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic [4:0] rd,
                                 input logic [DW-1:0] d);
        wb_valid[i]        = v;
        wb_rd[5*i +: 5]    = rd;
        wb_data[DW*i +: DW] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb_valid = 3'b111;
        wb_rd = '0;
        issue_rd = 5'd5;
        tick();
        tick();
        checks++;
        if (wb_ready !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_wb_ready: got %b expected 000", wb_ready);
        end
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_rf: got we=%b rd=%0d data=%h expected 0/0/0", rf_we, rf_rd, rf_data);
        end
        checks++;
        if (issue_ready !== 1'b0 || wb_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_issue_err: got ready=%b err=%b expected 0/0", issue_ready, wb_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (wb_ready !== 3'b001) begin
            failures++;
            $display("[TB] FAIL reset_first_grant: got %b expected 001", wb_ready);
        end
        wb_valid = 3'b000;
        tick();
    endtask

    task automatic test_round_robin();
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rr_issue_ready: got %b expected 1", issue_ready);
        end
        tick();
        issue_rd = 5'd6;
        tick();
        issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd5;
        rs2 = 5'd7;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rr_busy_set: got %b%b expected 11", rs1_busy, rs2_busy);
        end
        applyStimulus(0, 1'b1, 5'd5, 64'h0000_0000_0000_00A5);
        applyStimulus(1, 1'b1, 5'd6, 64'h0000_0000_0000_00B6);
        applyStimulus(2, 1'b1, 5'd7, 64'h0000_0000_0000_00C7);
        #1;
        checks++;
        if (wb_ready !== 3'b001) begin
            failures++;
            $display("[TB] FAIL rr_grant0: got %b expected 001", wb_ready);
        end
        tick();
        wb_valid[0] = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 64'hA5 || rs1_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rr_write5: got we=%b rd=%0d data=%h busy=%b expected 1/5/a5/0",
                     rf_we, rf_rd, rf_data, rs1_busy);
        end
        checks++;
        if (wb_ready !== 3'b010) begin
            failures++;
            $display("[TB] FAIL rr_grant1: got %b expected 010", wb_ready);
        end
        tick();
        wb_valid[1] = 1'b0;
        rs1 = 5'd6;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd6 || rf_data !== 64'hB6 || rs1_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rr_write6: got we=%b rd=%0d data=%h busy=%b expected 1/6/b6/0",
                     rf_we, rf_rd, rf_data, rs1_busy);
        end
        checks++;
        if (wb_ready !== 3'b100 || rs2_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rr_grant2: got %b busy7=%b expected 100/1", wb_ready, rs2_busy);
        end
        tick();
        wb_valid[2] = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 64'hC7 || rs2_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rr_write7: got we=%b rd=%0d data=%h busy=%b expected 1/7/c7/0",
                     rf_we, rf_rd, rf_data, rs2_busy);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || wb_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rr_idle: got we=%b err=%b expected 0/0", rf_we, wb_err);
        end
    endtask

    task automatic test_hold();
        int cycles;
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        applyStimulus(0, 1'b1, 5'd0, 64'h1111);
        applyStimulus(1, 1'b1, 5'd9, 64'hDEAD_BEEF_0000_0001);
        #1;
        checks++;
        if (wb_ready !== 3'b001) begin
            failures++;
            $display("[TB] FAIL hold_first: got %b expected 001", wb_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_rd0_we: got %b expected 0", rf_we);
        end
        cycles = 0;
        while (!wb_ready[1] && cycles < N_SRC) begin
            tick();
            cycles++;
        end
        checks++;
        if (wb_ready[1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_grant: got %b expected 1 within %0d cycles", wb_ready[1], N_SRC);
        end
        tick();
        wb_valid = 3'b000;
        rs1 = 5'd9;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 64'hDEAD_BEEF_0000_0001) begin
            failures++;
            $display("[TB] FAIL hold_data: got we=%b rd=%0d data=%h expected 1/9/deadbeef00000001",
                     rf_we, rf_rd, rf_data);
        end
        checks++;
        if (rs1_busy !== 1'b0 || wb_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_busy_err: got busy=%b err=%b expected 0/0", rs1_busy, wb_err);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1;
        issue_rd = 5'd10;
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd10;
        rs2 = 5'd0;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || issue_ready !== 1'b0 || rs2_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sb_set: got busy=%b ready=%b x0busy=%b expected 1/0/0",
                     rs1_busy, issue_ready, rs2_busy);
        end
        applyStimulus(2, 1'b1, 5'd10, 64'h0A0A);
        #1;
        checks++;
        if (wb_ready !== 3'b100) begin
            failures++;
            $display("[TB] FAIL sb_grant: got %b expected 100", wb_ready);
        end
        tick();
        wb_valid = 3'b000;
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || issue_ready !== 1'b1 || rf_rd !== 5'd10 || wb_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sb_clear: got busy=%b ready=%b rd=%0d err=%b expected 0/1/10/0",
                     rs1_busy, issue_ready, rf_rd, wb_err);
        end
        tick();
    endtask

    task automatic test_corner_cases();
        applyStimulus(0, 1'b1, 5'd0, 64'h0BAD);
        #1;
        checks++;
        if (wb_ready !== 3'b001) begin
            failures++;
            $display("[TB] FAIL cc_rd0_grant: got %b expected 001", wb_ready);
        end
        tick();
        wb_valid = 3'b000;
        #1;
        checks++;
        if (rf_we !== 1'b0 || wb_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cc_rd0: got we=%b err=%b expected 0/0", rf_we, wb_err);
        end
        applyStimulus(1, 1'b1, 5'd3, 64'h3333);
        tick();
        wb_valid = 3'b000;
        #1;
        checks++;
        if (wb_err !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_data !== 64'h3333) begin
            failures++;
            $display("[TB] FAIL cc_err_set: got err=%b we=%b rd=%0d data=%h expected 1/1/3/3333",
                     wb_err, rf_we, rf_rd, rf_data);
        end
        tick();
        tick();
        checks++;
        if (wb_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cc_err_sticky: got %b expected 1", wb_err);
        end
        issue_valid = 1'b1;
        issue_rd = 5'd4;
        applyStimulus(2, 1'b1, 5'd4, 64'h4444);
        tick();
        issue_valid = 1'b0;
        wb_valid = 3'b000;
        rs1 = 5'd4;
        #1;
        checks++;
        if (rs1_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cc_same_edge: got busy4=%b expected 1", rs1_busy);
        end
    endtask

    task automatic test_mid_reset();
        issue_valid = 1'b1;
        issue_rd = 5'd1;
        tick();
        issue_rd = 5'd2;
        tick();
        issue_valid = 1'b0;
        applyStimulus(0, 1'b1, 5'd1, 64'h0101);
        tick();
        wb_valid = 3'b000;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd1) begin
            failures++;
            $display("[TB] FAIL mr_inflight: got we=%b rd=%0d expected 1/1", rf_we, rf_rd);
        end
        rst = 1'b1;
        applyStimulus(1, 1'b1, 5'd2, 64'h0202);
        #1;
        checks++;
        if (wb_ready !== 3'b000 || issue_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mr_gated: got ready=%b issue=%b expected 000/0", wb_ready, issue_ready);
        end
        tick();
        rst = 1'b0;
        wb_valid = 3'b000;
        rs1 = 5'd2;
        rs2 = 5'd4;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || wb_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mr_cleared: got we=%b b2=%b b4=%b err=%b expected 0/0/0/0",
                     rf_we, rs1_busy, rs2_busy, wb_err);
        end
        applyStimulus(0, 1'b1, 5'd0, 64'h0);
        applyStimulus(2, 1'b1, 5'd0, 64'h0);
        #1;
        checks++;
        if (wb_ready !== 3'b001) begin
            failures++;
            $display("[TB] FAIL mr_ptr: got %b expected 001", wb_ready);
        end
        wb_valid = 3'b000;
        tick();
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b1;
        wb_valid = '0;
        wb_rd = '0;
        wb_data = '0;
        issue_valid = 1'b0;
        issue_rd = '0;
        rs1 = '0;
        rs2 = '0;
        test_reset();
        test_round_robin();
        test_hold();
        test_scoreboard();
        test_corner_cases();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
